rename_stage: RTL and testbench

Front-end rename stage: takes decoded instructions, maps architectural registers to physical registers, allocates destination registers from a free list, and assigns ROB tags. It is the producer side of the `rename_data` valid/ready interface consumed by `dispatch`. It holds one branch checkpoint for single-cycle mispredict recovery. It returns physical registers to the free list at ROB retirement.

---
 rtl/rename_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_rename_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rename_stage.sv
`default_nettype none
// ============================================================================
//  Module   : rename_stage
//  Purpose  : Register rename. Maps architectural sources through a map
//             table, allocates destinations from a circular free list and
//             assigns ROB tags. Keeps one branch checkpoint for one-cycle
//             mispredict recovery. Returns registers to the free list at
//             retirement.
//  Options  : RENAME_PERF_EN adds perf_renamed / perf_stall counters.
//  Revision : 1.0  initial release
// ============================================================================

package rename_pkg;
    localparam int PTAG_W = 7;
    localparam int ATAG_W = 5;
    localparam int RTAG_W = 5;

    typedef struct packed {
        logic              fu_alu;
        logic              fu_mem;
        logic              fu_br;
        logic [6:0]        Opcode;
        logic [31:0]       imm;
        logic [RTAG_W-1:0] rob_tag;
        logic [PTAG_W-1:0] ps1;
        logic [PTAG_W-1:0] ps2;
        logic [PTAG_W-1:0] pd_new;
        logic [PTAG_W-1:0] pd_old;
    } rename_data;
endpackage

module rename_stage #(
    parameter int NUM_PREG  = 128,
    parameter int NUM_AREG  = 32,
    parameter int ROB_DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dec_valid,
    output logic                   dec_ready,
    input  logic [4:0]             dec_rs1,
    input  logic [4:0]             dec_rs2,
    input  logic [4:0]             dec_rd,
    input  logic [6:0]             dec_opcode,
    input  logic [31:0]            dec_imm,
    input  logic                   dec_fu_alu,
    input  logic                   dec_fu_mem,
    input  logic                   dec_fu_br,
    input  logic                   rob_full,
    output logic                   valid_out,
    output rename_pkg::rename_data data_out,
    input  logic                   ready_in,
    input  logic                   retire_free_valid,
    input  logic [6:0]             retire_pd_old,
    input  logic                   mispredict,
    input  logic [4:0]             mispredict_tag,
`ifdef RENAME_PERF_EN
    output logic [31:0]            perf_renamed,
    output logic [31:0]            perf_stall,
`endif
    input  logic                   br_resolve_valid
);
    import rename_pkg::*;

    localparam int FL_DEPTH = NUM_PREG - NUM_AREG;
    localparam int FL_PW    = $clog2(FL_DEPTH);

    logic [PTAG_W-1:0] map_q    [NUM_AREG];
    logic [PTAG_W-1:0] ckpt_map [NUM_AREG];
    logic [PTAG_W-1:0] fl_mem   [FL_DEPTH];

    logic [FL_PW-1:0]  head, tail, ckpt_head, head_nxt;
    logic              head_wrap, tail_wrap, ckpt_head_wrap, head_wrap_nxt;
    logic [RTAG_W-1:0] tag;
    logic              ckpt_busy;

    logic              fl_empty, stall, accept, alloc, recover, take_ckpt;
    logic [PTAG_W-1:0] alloc_preg;
    rename_data        next_data;

    function automatic logic [FL_PW-1:0] ptr_inc(input logic [FL_PW-1:0] p);
        return (p == FL_PW'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [RTAG_W-1:0] tag_inc(input logic [RTAG_W-1:0] t);
        return (t == RTAG_W'(ROB_DEPTH - 1)) ? '0 : t + 1'b1;
    endfunction

    // Equal pointers mean empty when the wrap bits agree, full when they differ
    assign fl_empty  = (head == tail) && (head_wrap == tail_wrap);
    assign stall     = (valid_out & ~ready_in) | fl_empty | rob_full | mispredict
                     | (dec_fu_br & ckpt_busy);
    assign dec_ready = ~stall;
    assign accept    = dec_valid & dec_ready;
    assign alloc     = accept & (dec_rd != 5'd0);
    assign recover   = mispredict & ckpt_busy;
    assign take_ckpt = accept & dec_fu_br;

    assign alloc_preg    = fl_mem[head];
    assign head_nxt      = ptr_inc(head);
    assign head_wrap_nxt = (head == FL_PW'(FL_DEPTH - 1)) ? ~head_wrap : head_wrap;

    // Build the renamed payload from the current map and free-list head
    always_comb begin
        next_data         = '0;
        next_data.fu_alu  = dec_fu_alu;
        next_data.fu_mem  = dec_fu_mem;
        next_data.fu_br   = dec_fu_br;
        next_data.Opcode  = dec_opcode;
        next_data.imm     = dec_imm;
        next_data.rob_tag = tag;
        next_data.ps1     = (dec_rs1 == 5'd0) ? '0 : map_q[dec_rs1];
        next_data.ps2     = (dec_rs2 == 5'd0) ? '0 : map_q[dec_rs2];
        next_data.pd_new  = alloc ? alloc_preg    : '0;
        next_data.pd_old  = alloc ? map_q[dec_rd] : '0;
    end

    // Map table update and branch snapshot (snapshot includes this cycle's write)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_AREG; i++) begin
                map_q[i]    <= PTAG_W'(i);
                ckpt_map[i] <= PTAG_W'(i);
            end
        end else if (recover) begin
            for (int i = 0; i < NUM_AREG; i++) begin
                map_q[i] <= ckpt_map[i];
            end
        end else begin
            if (alloc) begin
                map_q[dec_rd] <= alloc_preg;
            end
            if (take_ckpt) begin
                for (int i = 0; i < NUM_AREG; i++) begin
                    ckpt_map[i] <= (alloc && dec_rd == ATAG_W'(i)) ? alloc_preg : map_q[i];
                end
            end
        end
    end

    // Free list: frees always land at the tail; the head follows alloc/recovery
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_mem[i] <= PTAG_W'(NUM_AREG + i);
            end
            head           <= '0;
            head_wrap      <= 1'b0;
            tail           <= '0;
            tail_wrap      <= 1'b1;
            ckpt_head      <= '0;
            ckpt_head_wrap <= 1'b0;
        end else begin
            if (retire_free_valid) begin
                fl_mem[tail] <= retire_pd_old;
                tail         <= ptr_inc(tail);
                if (tail == FL_PW'(FL_DEPTH - 1)) begin
                    tail_wrap <= ~tail_wrap;
                end
            end
            if (recover) begin
                head      <= ckpt_head;
                head_wrap <= ckpt_head_wrap;
            end else if (alloc) begin
                head      <= head_nxt;
                head_wrap <= head_wrap_nxt;
            end
            if (take_ckpt) begin
                ckpt_head      <= alloc ? head_nxt      : head;
                ckpt_head_wrap <= alloc ? head_wrap_nxt : head_wrap;
            end
        end
    end

    // Output register, ROB tag counter and checkpoint ownership
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            tag       <= '0;
            ckpt_busy <= 1'b0;
        end else begin
            if (recover) begin
                valid_out <= 1'b0;
            end else if (accept) begin
                valid_out <= 1'b1;
                data_out  <= next_data;
            end else if (ready_in) begin
                valid_out <= 1'b0;
            end

            if (recover) begin
                tag <= tag_inc(mispredict_tag);
            end else if (accept) begin
                tag <= tag_inc(tag);
            end

            if (recover || br_resolve_valid) begin
                ckpt_busy <= 1'b0;
            end else if (take_ckpt) begin
                ckpt_busy <= 1'b1;
            end
        end
    end

`ifdef RENAME_PERF_EN
    // Saturating counts of renamed instructions and stalled decode cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_renamed <= '0;
            perf_stall   <= '0;
        end else begin
            if (accept && (perf_renamed != '1)) begin
                perf_renamed <= perf_renamed + 32'd1;
            end
            if (dec_valid && !dec_ready && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rename_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rename_stage
//  Purpose  : Scoreboard bench for rename_stage. Stimulus pushes hand-computed
//             expected payloads; a monitor pops and compares each handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rename_stage;
    import rename_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dec_valid, dec_ready;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [6:0]  dec_opcode;
    logic [31:0] dec_imm;
    logic        dec_fu_alu, dec_fu_mem, dec_fu_br;
    logic        rob_full, valid_out, ready_in;
    rename_data  data_out;
    logic        retire_free_valid;
    logic [6:0]  retire_pd_old;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic        br_resolve_valid;

    rename_data  exp_q[$];
    rename_data  mon_e;
    int          n_pass = 0;
    int          n_total = 0;
    int          w;

    rename_stage dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_opcode(dec_opcode), .dec_imm(dec_imm),
        .dec_fu_alu(dec_fu_alu), .dec_fu_mem(dec_fu_mem), .dec_fu_br(dec_fu_br),
        .rob_full(rob_full), .valid_out(valid_out), .data_out(data_out),
        .ready_in(ready_in), .retire_free_valid(retire_free_valid),
        .retire_pd_old(retire_pd_old), .mispredict(mispredict),
        .mispredict_tag(mispredict_tag), .br_resolve_valid(br_resolve_valid)
    );

    always #5 clk = ~clk;

    function automatic string fmt(input rename_data d);
        return $sformatf("alu=%0b mem=%0b br=%0b op=%h imm=%h tag=%0d ps1=%0d ps2=%0d pd_new=%0d pd_old=%0d",
                         d.fu_alu, d.fu_mem, d.fu_br, d.Opcode, d.imm, d.rob_tag,
                         d.ps1, d.ps2, d.pd_new, d.pd_old);
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every handshake must match the oldest expectation
    always @(negedge clk) begin
        if (reset && valid_out && ready_in) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_unexpected: got %s required nothing", fmt(data_out));
            end else begin
                mon_e = exp_q.pop_front();
                if (data_out === mon_e) n_pass++;
                else $display("FAIL out_tag%0d: got %s required %s", mon_e.rob_tag, fmt(data_out), fmt(mon_e));
            end
        end
    end

    task automatic drive(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic br);
        dec_valid  = 1'b1;
        dec_rd     = rd;
        dec_rs1    = rs1;
        dec_rs2    = rs2;
        dec_fu_br  = br;
        dec_fu_alu = !br;
        dec_fu_mem = 1'b0;
        dec_opcode = br ? 7'h63 : 7'h33;
        dec_imm    = {16'hC0DE, 3'b000, rd, 3'b000, rs1};
    endtask

    // Present one instruction, wait for acceptance and record its expected payload
    task automatic send(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                        input logic [4:0] etag, input logic [6:0] eps1, input logic [6:0] eps2,
                        input logic [6:0] epdn, input logic [6:0] epdo, output int waited);
        rename_data e;
        drive(rd, rs1, rs2, br);
        waited = 0;
        @(negedge clk);
        while (!dec_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!dec_ready) begin
            n_total++;
            $display("FAIL send_timeout: got dec_ready=0 required 1 (rd=%0d)", rd);
        end else begin
            e.fu_alu  = !br;
            e.fu_mem  = 1'b0;
            e.fu_br   = br;
            e.Opcode  = br ? 7'h63 : 7'h33;
            e.imm     = {16'hC0DE, 3'b000, rd, 3'b000, rs1};
            e.rob_tag = etag;
            e.ps1     = eps1;
            e.ps2     = eps2;
            e.pd_new  = epdn;
            e.pd_old  = epdo;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        dec_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        int prev;
        int pdn;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_opcode = 0; dec_imm = 0;
        dec_fu_alu = 0; dec_fu_mem = 0; dec_fu_br = 0; rob_full = 0; ready_in = 1;
        retire_free_valid = 0; retire_pd_old = 0; mispredict = 0; mispredict_tag = 0;
        br_resolve_valid = 0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_dec_ready", dec_ready, 1);
        @(posedge clk); #1;

        // first instruction and dependency chain
        send(5, 1, 2, 0,  0,  1,  2, 32,  5, w);
        send(5, 0, 0, 0,  1,  0,  0, 33, 32, w);
        send(6, 5, 3, 0,  2, 33,  3, 34,  6, w);
        // branch tag 3, then two writers of x4
        send(0, 5, 6, 1,  3, 33, 34,  0,  0, w);
        send(4, 1, 0, 0,  4,  1,  0, 35,  4, w);
        send(4, 4, 0, 0,  5, 35,  0, 36, 35, w);
        idle(2);

        // mispredict back to the branch
        mispredict = 1; mispredict_tag = 3;
        @(negedge clk);
        chk("mp_stall", dec_ready, 0);
        @(posedge clk); #1 mispredict = 0;
        send(4, 4, 0, 0,  4,  4,  0, 35,  4, w);
        chk("mp_accept_next", w, 0);

        // second branch blocked while the checkpoint is held
        send(0, 0, 0, 1,  5,  0,  0,  0,  0, w);
        drive(0, 0, 0, 1);
        @(negedge clk); chk("br_busy_stall0", dec_ready, 0);
        @(negedge clk); chk("br_busy_stall1", dec_ready, 0);
        @(posedge clk); #1 br_resolve_valid = 1;
        @(negedge clk); chk("br_resolve_cycle", dec_ready, 0);
        @(posedge clk); #1 br_resolve_valid = 0;
        send(0, 0, 0, 1,  6,  0,  0,  0,  0, w);
        chk("br_accept_next", w, 0);
        br_resolve_valid = 1;
        @(posedge clk); #1 br_resolve_valid = 0;

        // mispredict without a checkpoint must not touch the tag counter
        mispredict = 1; mispredict_tag = 20;
        @(posedge clk); #1 mispredict = 0;
        idle(1);

        // backpressure: output held, decode stalled
        ready_in = 0;
        send(7, 0, 0, 0,  7,  0,  0, 36,  7, w);
        repeat (3) begin
            @(negedge clk);
            chk("bp_dec_ready", dec_ready, 0);
            chk("bp_hold_pd_new", data_out.pd_new, 36);
            chk("bp_hold_tag", data_out.rob_tag, 7);
        end
        @(posedge clk); #1 ready_in = 1;

        // x0 destination allocates nothing
        send(0, 7, 4, 0,  8, 36, 35,  0,  0, w);
        send(8, 0, 0, 0,  9,  0,  0, 37,  8, w);

        // allocate and free p5 in the same cycle
        retire_free_valid = 1; retire_pd_old = 5;
        send(9, 0, 0, 0, 10,  0,  0, 38,  9, w);
        retire_free_valid = 0;
        chk("alloc_free_no_wait", w, 0);

        // drain the free list: 89 fresh registers then the freed p5
        prev = 10;
        for (int k = 0; k < 90; k++) begin
            pdn = (k < 89) ? (39 + k) : 5;
            send(10, 0, 0, 0, 5'(11 + k), 0, 0, 7'(pdn), 7'(prev), w);
            prev = pdn;
        end
        drive(11, 10, 0, 0);
        @(negedge clk); chk("empty_stall", dec_ready, 0);
        @(posedge clk); #1 retire_free_valid = 1; retire_pd_old = 7;
        @(negedge clk); chk("freed_not_yet_alloc", dec_ready, 0);
        @(posedge clk); #1 retire_free_valid = 0;
        send(11, 10, 0, 0,  5,  5,  0,  7, 11, w);
        chk("wrap_alloc_no_wait", w, 0);

        // asynchronous reset discards the held output
        retire_free_valid = 1; retire_pd_old = 11;
        @(posedge clk); #1 retire_free_valid = 0;
        ready_in = 0;
        send(0, 0, 0, 0,  6,  0,  0,  0,  0, w);
        @(negedge clk); chk("pre_rst_valid", valid_out, 1);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_valid", valid_out, 0);
        chk("async_rst_data", data_out, 0);
        @(posedge clk); #1 reset = 1'b1; ready_in = 1;
        send(5, 5, 0, 0,  0,  5,  0, 32,  5, w);
        idle(3);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
